// File: rtl/select_fd_if.sv
// select_fd_if: operand/result bundle for the final quotient-selection stage.
// The master side (the datapath) drives operands; the slave side (select_fd)
// returns the registered quotient significand with its sticky bit.
// The optional exact flag is present only when SELECT_FD_EXACT_EN is defined.
interface select_fd_if;
   logic          in_valid;
   logic [57:0]   Da;
   logic [57:0]   Db;
   logic [114:0]  Eb;
   logic          db;
   logic [54:0]   E;
   logic [56:0]   fd;
   logic          out_valid;
`ifdef SELECT_FD_EXACT_EN
   logic          exact;

   modport master (
      output in_valid, Da, Db, Eb, db, E,
      input  fd, out_valid, exact
   );

   modport slave (
      input  in_valid, Da, Db, Eb, db, E,
      output fd, out_valid, exact
   );
`else
   modport master (
      output in_valid, Da, Db, Eb, db, E,
      input  fd, out_valid
   );

   modport slave (
      input  in_valid, Da, Db, Eb, db, E,
      output fd, out_valid
   );
`endif
endinterface

// File: rtl/select_fd.sv
// select_fd: final quotient-selection stage of the FPU multiplier/divider.
// Given an approximation E that is either exact or one ulp too large, the
// remainder R = {Da, 57'b0} - E*Db decides whether to keep E or step it down by
// one ulp, and whether the truncated quotient is inexact (sticky).
// Result is registered: one cycle from in_valid to out_valid.
// Optional feature macro: SELECT_FD_EXACT_EN adds a registered `exact` output
// flagging R == 0.
module select_fd (
   input  logic         clk,
   input  logic         rst,
   select_fd_if.slave   bus
);

   localparam int Q_W   = 55;
   localparam int FD_W  = 57;
   localparam int REM_W = 116;
   localparam int SP_LO = 29;   // quotient bits below this are unused in single precision

   // Step the quotient down by one ulp, clamping at zero instead of wrapping.
   function automatic logic [Q_W-1:0] sat_dec(input logic [Q_W-1:0] q,
                                              input logic [Q_W-1:0] u);
      logic [Q_W-1:0] res;
      if (q < u) begin
         res = '0;
      end else begin
         res = q - u;
      end
      return res;
   endfunction

   // Pack the quotient, a zero guard position and the sticky bit for the rounder.
   function automatic logic [FD_W-1:0] pack_fd(input logic [Q_W-1:0] q,
                                               input logic sticky);
      return {q, 1'b0, sticky};
   endfunction

   // ---- stage p0: combinational remainder and quotient selection ----
   logic [Q_W-1:0]    w_em_p0;
   logic [Q_W-1:0]    w_ulp_p0;
   logic [REM_W-1:0]  w_rem_p0;
   logic              w_rem_zero_p0;
   logic              w_rem_neg_p0;
   logic [Q_W-1:0]    w_q_p0;
   logic              w_sticky_p0;
   logic [FD_W-1:0]   w_fd_p0;
   logic              w_unused_db;

   // The divisor itself is not needed: its contribution arrives through Eb.
   assign w_unused_db = ^bus.Db;

   // Select ulp size and mask the approximation to the active precision.
   always_comb begin
      w_em_p0  = bus.E;
      w_ulp_p0 = {{(Q_W-1){1'b0}}, 1'b1};
      if (!bus.db) begin
         w_em_p0  = {bus.E[Q_W-1:SP_LO], {SP_LO{1'b0}}};
         w_ulp_p0 = {{(Q_W-SP_LO-1){1'b0}}, 1'b1, {SP_LO{1'b0}}};
      end
   end

   // Remainder as a 116-bit two's-complement value; both operands zero-extended.
   assign w_rem_p0      = {1'b0, bus.Da, 57'b0} - {1'b0, bus.Eb};
   assign w_rem_zero_p0 = (w_rem_p0 == '0);
   assign w_rem_neg_p0  = w_rem_p0[REM_W-1];

   // Keep Em when R >= 0, otherwise Em was one ulp too large; any nonzero R is inexact.
   always_comb begin
      w_q_p0      = w_em_p0;
      w_sticky_p0 = ~w_rem_zero_p0;
      if (w_rem_neg_p0) begin
         w_q_p0 = sat_dec(w_em_p0, w_ulp_p0);
      end
      w_fd_p0 = pack_fd(w_q_p0, w_sticky_p0);
   end

   // ---- stage p1: output registers ----
   logic [FD_W-1:0] r_fd_p1;
   logic            r_vld_p1;

   // Valid follows in_valid every cycle; no stall or backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p1 <= 1'b0;
      end else begin
         r_vld_p1 <= bus.in_valid;
      end
   end

   // Capture the result only on valid operands so idle inputs never reach fd.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fd_p1 <= '0;
      end else if (bus.in_valid) begin
         r_fd_p1 <= w_fd_p0;
      end
   end

`ifdef SELECT_FD_EXACT_EN
   logic r_exact_p1;

   // Exact flag registered alongside fd and held while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exact_p1 <= 1'b0;
      end else if (bus.in_valid) begin
         r_exact_p1 <= w_rem_zero_p0;
      end
   end

   assign bus.exact = r_exact_p1;
`endif

   assign bus.fd        = r_fd_p1;
   assign bus.out_valid = r_vld_p1;

endmodule

// File: tb/tb_select_fd.sv
// tb_select_fd: directed bench for select_fd with hand-computed expected values.
module tb_select_fd;
   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   select_fd_if bus();

   select_fd dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_fd(input string tag, input logic [56:0] obs, input logic [56:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s fd observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   // Present one operand set on the falling edge, then sample 1 time unit after the next rise.
   task automatic step(input logic v, input logic d, input logic [54:0] e,
                       input logic [57:0] da, input logic [114:0] eb);
      @(negedge clk);
      bus.in_valid = v;
      bus.db       = d;
      bus.E        = e;
      bus.Da       = da;
      bus.Db       = 58'h1;
      bus.Eb       = eb;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.db       = 1'bx;
      bus.E        = 'x;
      bus.Da       = 'x;
      bus.Db       = 'x;
      bus.Eb       = 'x;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.db = 1'b1;
      bus.E  = '0;
      bus.Da = '0;
      bus.Db = '0;
      bus.Eb = '0;

      repeat (2) @(posedge clk);
      #1;
      chk_fd ("reset_fd", bus.fd, 57'h0);
      chk_bit("reset_vld", bus.out_valid, 1'b0);
`ifdef SELECT_FD_EXACT_EN
      chk_bit("reset_exact", bus.exact, 1'b0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // exact double: R == 0
      step(1'b1, 1'b1, 55'h10, 58'h1, (115'h1 << 57));
      chk_fd ("exact_dp", bus.fd, 57'h40);
      chk_bit("exact_dp_vld", bus.out_valid, 1'b1);
`ifdef SELECT_FD_EXACT_EN
      chk_bit("exact_dp_flag", bus.exact, 1'b1);
`endif

      // one ulp too large: R = -1
      step(1'b1, 1'b1, 55'h10, 58'h1, (115'h1 << 57) + 115'h1);
      chk_fd("toolarge_dp", bus.fd, 57'h3D);
`ifdef SELECT_FD_EXACT_EN
      chk_bit("toolarge_dp_flag", bus.exact, 1'b0);
`endif

      // single precision, R > 0, low 29 bits masked
      step(1'b1, 1'b0, 55'h1555555555555, 58'h1, 115'h0);
      chk_fd("sp_rpos", bus.fd, 57'h5555500000001);

      // single precision clamp: Em = 0 and R < 0
      step(1'b1, 1'b0, 55'h10, 58'h1, (115'h1 << 57) + 115'h5);
      chk_fd("sp_clamp", bus.fd, 57'h1);

      // double precision, R = +1
      step(1'b1, 1'b1, 55'h10, 58'h1, (115'h1 << 57) - 115'h1);
      chk_fd("dp_rpos", bus.fd, 57'h41);

      // single precision R < 0 without clamp: q = (3<<29) - (1<<29)
      step(1'b1, 1'b0, (55'h3 << 29), 58'h1, (115'h1 << 57) + 115'h1);
      chk_fd("sp_rneg", bus.fd, 57'h100000001);

      // double precision clamp: E = 0 and R < 0
      step(1'b1, 1'b1, 55'h0, 58'h1, (115'h1 << 57) + 115'h1);
      chk_fd("dp_clamp", bus.fd, 57'h1);

      // large dividend, wide remainder: Da all ones, Eb = 0
      step(1'b1, 1'b1, 55'h7F, {58{1'b1}}, 115'h0);
      chk_fd("dp_bigda", bus.fd, 57'h1FD);

      // throughput: three back-to-back operands, then idle with X inputs
      step(1'b1, 1'b1, 55'h10, 58'h1, (115'h1 << 57));
      chk_fd ("b2b_0", bus.fd, 57'h40);
      chk_bit("b2b_0_vld", bus.out_valid, 1'b1);
      step(1'b1, 1'b1, 55'h10, 58'h1, (115'h1 << 57) + 115'h1);
      chk_fd ("b2b_1", bus.fd, 57'h3D);
      chk_bit("b2b_1_vld", bus.out_valid, 1'b1);
      step(1'b1, 1'b0, (55'h1 << 29) | 55'h5, 58'h1, (115'h1 << 57));
      chk_fd ("b2b_2_sp_exact", bus.fd, 57'h80000000);
      chk_bit("b2b_2_vld", bus.out_valid, 1'b1);
`ifdef SELECT_FD_EXACT_EN
      chk_bit("b2b_2_flag", bus.exact, 1'b1);
`endif
      idle();
      chk_bit("idle_vld", bus.out_valid, 1'b0);
      chk_fd ("idle_hold", bus.fd, 57'h80000000);
      idle();
      chk_fd ("idle_hold2", bus.fd, 57'h80000000);
`ifdef SELECT_FD_EXACT_EN
      chk_bit("idle_hold_flag", bus.exact, 1'b1);
`endif

      // asynchronous reset mid-cycle with a valid result on the outputs
      step(1'b1, 1'b1, 55'h10, 58'h1, (115'h1 << 57) + 115'h1);
      chk_fd("pre_rst", bus.fd, 57'h3D);
      #2;
      rst = 1'b1;
      #1;
      chk_fd ("async_rst_fd", bus.fd, 57'h0);
      chk_bit("async_rst_vld", bus.out_valid, 1'b0);
      @(posedge clk);
      #1;
      chk_bit("rst_held_vld", bus.out_valid, 1'b0);
      chk_fd ("rst_held_fd", bus.fd, 57'h0);
      @(negedge clk);
      rst = 1'b0;

      // recovery after reset
      step(1'b1, 1'b1, 55'h20, 58'h2, (115'h1 << 58));
      chk_fd ("recover", bus.fd, 57'h80);
      chk_bit("recover_vld", bus.out_valid, 1'b1);
      idle();
      chk_bit("final_vld", bus.out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Bound the run so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
